// File: rtl/clk_div.sv
// Integer clock divider feeding the UART TX/RX clock domains; passes CLK through when N < 2 or disabled.
// Optional `CLKDIV_PERIOD_TICK_EN adds PERIOD_TICK, a one-cycle pulse at the start of each divided period.
module clk_div #(
    parameter int RATIO_WD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLK_EN,
    input  logic [RATIO_WD-1:0] DIV_RATIO,
    output logic                DIV_CLK
`ifdef CLKDIV_PERIOD_TICK_EN
    ,
    output logic                PERIOD_TICK
`endif
);

    typedef enum logic {
        st_low  = 1'b0,
        st_high = 1'b1
    } state_t;

    localparam logic [RATIO_WD-1:0] one = RATIO_WD'(1);
    localparam logic [RATIO_WD-1:0] two = RATIO_WD'(2);

    // state_q doubles as div_q and is the FSM state observed by checkers
    state_t              state_q;
    logic [RATIO_WD-1:0] ratio_q;
    logic [RATIO_WD-1:0] cnt;
    logic [RATIO_WD-1:0] lo_len;
    logic [RATIO_WD-1:0] hi_len;
    logic                div_q;
    logic                bypass;
    logic                lo_done;
    logic                hi_done;

    assign div_q   = (state_q == st_high);
    assign bypass  = !CLK_EN || (ratio_q < two);
    assign lo_len  = ratio_q >> 1;
    assign hi_len  = ratio_q - lo_len;
    // Only consulted while ratio_q >= 2, so neither subtraction underflows
    assign lo_done = (cnt == lo_len - one);
    assign hi_done = (cnt == hi_len - one);

    // The single mux on the clock path
    assign DIV_CLK = bypass ? CLK : div_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ratio_q <= '0;
            cnt     <= '0;
            state_q <= st_low;
        end else if (bypass) begin
            ratio_q <= DIV_RATIO;
            cnt     <= '0;
            state_q <= st_low;
        end else begin
            case (state_q)
                st_low: begin
                    if (lo_done) begin
                        cnt     <= '0;
                        state_q <= st_high;
                    end else begin
                        cnt <= cnt + one;
                    end
                end
                st_high: begin
                    if (hi_done) begin
                        cnt     <= '0;
                        state_q <= st_low;
                        ratio_q <= DIV_RATIO;
                    end else begin
                        cnt <= cnt + one;
                    end
                end
                default: begin
                    cnt     <= '0;
                    state_q <= st_low;
                end
            endcase
        end
    end

`ifdef CLKDIV_PERIOD_TICK_EN
    logic tick_q;

    // No pulse when the reloaded ratio drops the divider into bypass
    always_ff @(posedge CLK) begin
        if (RST || bypass) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= (state_q == st_high) && hi_done && (DIV_RATIO >= two);
        end
    end

    assign PERIOD_TICK = tick_q;
`endif

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: period-level reference model checked on both clock halves,
// plus hand-computed DIV_CLK / PERIOD_TICK sequences for each scenario.
module tb_clk_div;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         CLK_EN = 1'b1;
    logic [W-1:0] DIV_RATIO = W'(4);
    logic         DIV_CLK;
`ifdef CLKDIV_PERIOD_TICK_EN
    logic         PERIOD_TICK;
`endif

    always #5 CLK = ~CLK;

    clk_div #(.RATIO_WD(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLK_EN     (CLK_EN),
        .DIV_RATIO  (DIV_RATIO),
        .DIV_CLK    (DIV_CLK)
`ifdef CLKDIV_PERIOD_TICK_EN
        ,
        .PERIOD_TICK(PERIOD_TICK)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Period model: active ratio and position inside the current output period
    int m_ratio = 0;
    int m_pos   = 0;
    bit m_tick  = 1'b0;
    bit m_valid = 1'b0;

    function automatic logic exp_clk();
        if (!CLK_EN || m_ratio < 2) return CLK;
        return (m_pos >= m_ratio / 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_edge();
        if (RST) begin
            m_ratio = 0;
            m_pos   = 0;
            m_tick  = 1'b0;
            m_valid = 1'b1;
        end else if (!CLK_EN || m_ratio < 2) begin
            m_ratio = int'(DIV_RATIO);
            m_pos   = 0;
            m_tick  = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_pos++;
            if (m_pos == m_ratio) begin
                m_pos   = 0;
                m_ratio = int'(DIV_RATIO);
                m_tick  = (DIV_RATIO >= 2);
            end
        end
    endtask

    task automatic compare();
        if (m_valid) begin
            check("div_clk_model", DIV_CLK, exp_clk());
`ifdef CLKDIV_PERIOD_TICK_EN
            check("tick_model", PERIOD_TICK, m_tick);
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            model_edge();
            #2;
            compare();
            @(negedge CLK);
            #3;
            compare();
        end
    end

    // Stimulus helpers: the stimulus process always rests at negedge+1
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic run_seq(input string name, input int n, input logic [31:0] bits);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
            check(name, DIV_CLK, exp_q.pop_front());
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input int ratio, input logic en);
        RST       = 1'b1;
        DIV_RATIO = W'(ratio);
        CLK_EN    = en;
        idle(2);
        RST = 1'b0;
    endtask

    initial begin
        // Reset with N=4: CLK passes through, then 2 low / 2 high
        idle(1);
        run_seq("reset_bypass", 2, 32'b11);
        RST = 1'b0;
        run_seq("n4_after_reset", 8, 32'b00110011);
        idle(12);

        // Odd ratio: low 2, high 3
        do_reset(5, 1'b1);
        run_seq("n5_odd", 10, 32'b0011100111);
        idle(45);

        // Ratio change in the low phase finishes the 2/2 period, then 3/3
        do_reset(4, 1'b1);
        run_seq("mid_pre", 1, 32'b0);
        DIV_RATIO = W'(6);
        run_seq("mid_change", 9, 32'b011000111);
        idle(12);

        // N=1 is bypass; switching to 2 loads on the next edge, then 1/1
        do_reset(1, 1'b1);
        run_seq("n1_bypass", 4, 32'b1111);
        DIV_RATIO = W'(2);
        run_seq("n2_toggle", 6, 32'b010101);

        // Enable drop in the high phase at N=8
        do_reset(8, 1'b1);
        run_seq("n8_low", 4, 32'b0000);
        run_seq("n8_high", 2, 32'b11);
        check("en_before_drop", DIV_CLK, 1'b1);
        CLK_EN = 1'b0;
        #1;
        check("en_drop_follows_clk", DIV_CLK, 1'b0);
        @(negedge CLK);
        #1;
        run_seq("en_off_bypass", 2, 32'b11);
        // ratio_q already holds 8 and cnt is 0, so the low phase is under way once enable rises
        CLK_EN = 1'b1;
        run_seq("en_rise", 8, 32'b00011110);
        idle(10);

        // Ratio 0 holds bypass
        DIV_RATIO = W'(0);
        idle(10);
        run_seq("n0_bypass", 3, 32'b111);

`ifdef CLKDIV_PERIOD_TICK_EN
        // N=3: tick in the first cycle of each period after the first
        do_reset(3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            logic [5:0] tick_exp;
            tick_exp = 6'b000100;
            @(posedge CLK);
            #2;
            check("tick_n3", PERIOD_TICK, tick_exp[5-i]);
            @(negedge CLK);
            #1;
        end
        idle(20);
        DIV_RATIO = W'(1);
        idle(10);
        check("tick_bypass", PERIOD_TICK, 1'b0);
`endif

        // Reset in the middle of a period
        do_reset(6, 1'b1);
        idle(7);
        RST = 1'b1;
        run_seq("mid_reset", 1, 32'b1);
        RST = 1'b0;
        run_seq("after_mid_reset", 6, 32'b000111);
        idle(10);

        // Largest ratio: 127 low, 128 high, over two periods
        do_reset(255, 1'b1);
        idle(520);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
